// File: rtl/pwm_sched_pkg.sv
`default_nettype none
// ============================================================================
// pwm_sched_pkg : shared widths, scale constants and types for the PWM duty
//                 scheduler.   Rev 1.0
// ============================================================================
package pwm_sched_pkg;

    localparam int DUTY_W    = 8;
    localparam int PCT_SCALE = 100;
    localparam int QUOT_BITS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } sched_state_t;

    typedef logic [1:0] ch_idx_t;

endpackage
`default_nettype wire

// File: rtl/pwm_seq_divider.sv
`default_nettype none
// ============================================================================
// pwm_seq_divider : restoring divider, one quotient bit per cycle, MSB first.
//                   Rev 1.0
// ============================================================================
module pwm_seq_divider
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W+6:0]     num,
    input  logic [CNT_W:0]       den,
    output logic [QUOT_BITS-1:0] quot,
    output logic                 done
);

    localparam int c_rem_w = CNT_W + 8;

    logic [c_rem_w-1:0]   r_rem;
    logic [c_rem_w-1:0]   r_dsh;
    logic [QUOT_BITS-1:0] r_quot;
    logic [2:0]           r_cnt;
    logic                 r_active;

    logic                 w_fit;
    logic [c_rem_w-1:0]   w_rem_sub;

    assign w_fit     = (r_rem >= r_dsh);
    assign w_rem_sub = r_rem - r_dsh;
    assign done      = r_active && (r_cnt == 3'(QUOT_BITS - 1));
    // The final quotient bit is folded in combinationally so the caller can
    // latch the full result on the same edge as the last iteration.
    assign quot      = {r_quot[QUOT_BITS-2:0], w_fit};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rem    <= '0;
            r_dsh    <= '0;
            r_quot   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= {1'b0, num};
            r_dsh    <= c_rem_w'(den) << (QUOT_BITS - 1);
            r_quot   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_fit) begin
                r_rem <= w_rem_sub;
            end
            r_dsh  <= r_dsh >> 1;
            r_quot <= {r_quot[QUOT_BITS-2:0], w_fit};
            r_cnt  <= r_cnt + 3'd1;
            if (done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// pwm_duty_scheduler : round-robin sharing of one duty-cycle divider among the
//                      R/G/B PWM measurement channels.   Rev 1.0
// ============================================================================
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int NUM_CH    = 3,
    parameter int PCT_SCALE = 100
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [NUM_CH-1:0]                     meas_valid,
    input  logic [NUM_CH*CNT_W-1:0]               on_cnt,
    input  logic [NUM_CH*CNT_W-1:0]               off_cnt,
    input  logic                                  ovr_clr,
    output logic [NUM_CH*pwm_sched_pkg::DUTY_W-1:0] duty,
    output logic [NUM_CH-1:0]                     duty_valid,
    output logic [NUM_CH-1:0]                     overrun,
    output logic                                  busy
);

    localparam int c_num_w = CNT_W + 7;

    logic [CNT_W-1:0]   r_on_buf  [NUM_CH];
    logic [CNT_W-1:0]   r_off_buf [NUM_CH];
    logic [DUTY_W-1:0]  r_duty    [NUM_CH];
    logic [NUM_CH-1:0]  r_pending;
    logic [NUM_CH-1:0]  r_overrun;
    logic [NUM_CH-1:0]  r_duty_valid;
    ch_idx_t            r_rr_ptr;
    ch_idx_t            r_grant;
    sched_state_t       r_state;
    logic [DUTY_W-1:0]  r_result;

    logic               w_found;
    ch_idx_t            w_pick;
    ch_idx_t            w_idx;
    logic               w_grant;
    logic [NUM_CH-1:0]  w_grant_oh;
    logic [CNT_W-1:0]   w_on_g;
    logic [CNT_W-1:0]   w_off_g;
    logic [CNT_W:0]     w_den;
    logic [c_num_w-1:0] w_num;
    logic               w_div_start;
    logic [QUOT_BITS-1:0] w_div_quot;
    logic               w_div_done;
    logic [DUTY_W-1:0]  w_quot_ext;
    logic [DUTY_W-1:0]  w_clamped;

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = ch_idx_t'((int'(r_rr_ptr) + k) % NUM_CH);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_grant     = (r_state == IDLE) && en && w_found;
    assign w_on_g      = r_on_buf[w_pick];
    assign w_off_g     = r_off_buf[w_pick];
    assign w_den       = {1'b0, w_on_g} + {1'b0, w_off_g};
    assign w_num       = c_num_w'(w_on_g) * c_num_w'(PCT_SCALE);
    assign w_div_start = w_grant && (w_den != '0);
    assign w_quot_ext  = {1'b0, w_div_quot};
    assign w_clamped   = (w_quot_ext > DUTY_W'(PCT_SCALE)) ? DUTY_W'(PCT_SCALE) : w_quot_ext;
    assign busy        = (r_state != IDLE);
    assign overrun     = r_overrun;
    assign duty_valid  = r_duty_valid;

    pwm_seq_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clock (clock),
        .reset (reset),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_den),
        .quot  (w_div_quot),
        .done  (w_div_done)
    );

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_grant_oh[i]              = w_grant && (w_pick == ch_idx_t'(i));
            assign duty[i*DUTY_W +: DUTY_W]   = r_duty[i];

            // A new capture in the grant cycle keeps the channel pending and is
            // not an overrun; the grant has already taken the old pair.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_on_buf[i]  <= '0;
                    r_off_buf[i] <= '0;
                    r_pending[i] <= 1'b0;
                    r_overrun[i] <= 1'b0;
                end else begin
                    if (meas_valid[i]) begin
                        r_on_buf[i]  <= on_cnt[i*CNT_W +: CNT_W];
                        r_off_buf[i] <= off_cnt[i*CNT_W +: CNT_W];
                        r_pending[i] <= 1'b1;
                    end else if (w_grant_oh[i]) begin
                        r_pending[i] <= 1'b0;
                    end
                    if (meas_valid[i] && r_pending[i] && !w_grant_oh[i]) begin
                        r_overrun[i] <= 1'b1;
                    end else if (ovr_clr) begin
                        r_overrun[i] <= 1'b0;
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_duty[i]       <= '0;
                    r_duty_valid[i] <= 1'b0;
                end else begin
                    r_duty_valid[i] <= 1'b0;
                    if ((r_state == WRITE) && (r_grant == ch_idx_t'(i))) begin
                        r_duty[i]       <= r_result;
                        r_duty_valid[i] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_grant <= w_pick;
                        if (w_den == '0) begin
                            r_result <= '0;
                            r_state  <= WRITE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (w_div_done) begin
                        r_result <= w_clamped;
                        r_state  <= WRITE;
                    end
                end
                WRITE: begin
                    r_rr_ptr <= (int'(r_grant) == NUM_CH - 1) ? '0 : r_grant + ch_idx_t'(1);
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pwm_duty_scheduler : directed self-checking bench for pwm_duty_scheduler.
//                         Rev 1.0
// ============================================================================
module tb_pwm_duty_scheduler;

    localparam int CNT_W  = 32;
    localparam int NUM_CH = 3;

    logic                      clock;
    logic                      reset;
    logic                      en;
    logic [NUM_CH-1:0]         meas_valid;
    logic [NUM_CH*CNT_W-1:0]   on_cnt;
    logic [NUM_CH*CNT_W-1:0]   off_cnt;
    logic                      ovr_clr;
    logic [NUM_CH*8-1:0]       duty;
    logic [NUM_CH-1:0]         duty_valid;
    logic [NUM_CH-1:0]         overrun;
    logic                      busy;

    int n_tests = 0;
    int n_fail  = 0;

    int rec_n;
    int rec_ch   [8];
    int rec_edge [8];
    int rec_val  [8];

    pwm_duty_scheduler #(
        .CNT_W     (CNT_W),
        .NUM_CH    (NUM_CH),
        .PCT_SCALE (100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .meas_valid (meas_valid),
        .on_cnt     (on_cnt),
        .off_cnt    (off_cnt),
        .ovr_clr    (ovr_clr),
        .duty       (duty),
        .duty_valid (duty_valid),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] dsel(input int ch);
        return duty[ch*8 +: 8];
    endfunction

    task automatic set_pair(input int ch, input int on_v, input int off_v);
        on_cnt[ch*CNT_W +: CNT_W]  = CNT_W'(on_v);
        off_cnt[ch*CNT_W +: CNT_W] = CNT_W'(off_v);
    endtask

    task automatic pulse(input logic [NUM_CH-1:0] mask);
        meas_valid = mask;
        tick();
        meas_valid = '0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int ch, output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (duty_valid[ch]) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic collect(input int n);
        rec_n = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            for (int c = 0; c < NUM_CH; c++) begin
                if (duty_valid[c] && rec_n < 8) begin
                    rec_ch[rec_n]   = c;
                    rec_edge[rec_n] = k;
                    rec_val[rec_n]  = int'(dsel(c));
                    rec_n++;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b1; meas_valid = '0; ovr_clr = 1'b0;
        on_cnt = '0; off_cnt = '0;
        #3;
        n_tests++; if (duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %h expected 0", duty); end
        n_tests++; if (duty_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", duty_valid); end
        n_tests++; if (overrun !== '0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 000", overrun); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single;
        int e;
        set_pair(1, 25, 75);
        pulse(3'b010);
        wait_valid(1, e);
        n_tests++; if (e != 9) begin n_fail++; $display("FAIL single_latency: got %0d edges expected 9", e); end
        n_tests++; if (dsel(1) !== 8'd25) begin n_fail++; $display("FAIL single_duty1: got %0d expected 25", dsel(1)); end
        n_tests++; if (dsel(0) !== 8'd0 || dsel(2) !== 8'd0) begin n_fail++; $display("FAIL single_others: got %0d/%0d expected 0/0", dsel(0), dsel(2)); end
        tick();
        n_tests++; if (duty_valid !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_pulse_end: got valid=%b busy=%b expected 000/0", duty_valid, busy); end
    endtask

    task automatic test_truncation;
        int e;
        set_pair(0, 1, 2);
        pulse(3'b001);
        wait_valid(0, e);
        n_tests++; if (e != 9 || dsel(0) !== 8'd33) begin n_fail++; $display("FAIL trunc_1_3: got %0d at edge %0d expected 33 at 9", dsel(0), e); end
        set_pair(0, 7, 0);
        pulse(3'b001);
        wait_valid(0, e);
        n_tests++; if (e != 9 || dsel(0) !== 8'd100) begin n_fail++; $display("FAIL full_scale: got %0d at edge %0d expected 100 at 9", dsel(0), e); end
    endtask

    task automatic test_round_robin;
        int exp_ch [3];
        int exp_val[3];
        int e;
        do_reset();
        set_pair(0, 50, 50); set_pair(1, 10, 90); set_pair(2, 90, 10);
        pulse(3'b111);
        collect(40);
        exp_ch  = '{0, 1, 2};
        exp_val = '{50, 10, 90};
        n_tests++; if (rec_n != 3) begin n_fail++; $display("FAIL rr0_count: got %0d pulses expected 3", rec_n); end
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (rec_ch[j] != exp_ch[j] || rec_edge[j] != 9*(j+1) || rec_val[j] != exp_val[j]) begin
                n_fail++;
                $display("FAIL rr0_slot%0d: got ch%0d edge %0d duty %0d expected ch%0d edge %0d duty %0d",
                         j, rec_ch[j], rec_edge[j], rec_val[j], exp_ch[j], 9*(j+1), exp_val[j]);
            end
        end
        // Servicing channel 1 alone moves the pointer to 2.
        set_pair(1, 1, 1);
        pulse(3'b010);
        wait_valid(1, e);
        set_pair(0, 1, 3); set_pair(1, 3, 1); set_pair(2, 1, 1);
        pulse(3'b111);
        collect(40);
        exp_ch  = '{2, 0, 1};
        exp_val = '{50, 25, 75};
        n_tests++; if (rec_n != 3) begin n_fail++; $display("FAIL rr2_count: got %0d pulses expected 3", rec_n); end
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (rec_ch[j] != exp_ch[j] || rec_edge[j] != 9*(j+1) || rec_val[j] != exp_val[j]) begin
                n_fail++;
                $display("FAIL rr2_slot%0d: got ch%0d edge %0d duty %0d expected ch%0d edge %0d duty %0d",
                         j, rec_ch[j], rec_edge[j], rec_val[j], exp_ch[j], 9*(j+1), exp_val[j]);
            end
        end
    endtask

    task automatic test_zero_den;
        int e, run, max_run;
        e = -1; run = 0; max_run = 0;
        set_pair(2, 0, 0);
        pulse(3'b100);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (duty_valid[2] && e < 0) e = k;
        end
        n_tests++; if (e != 2) begin n_fail++; $display("FAIL zero_den_latency: got %0d edges expected 2", e); end
        n_tests++; if (dsel(2) !== 8'd0) begin n_fail++; $display("FAIL zero_den_duty: got %0d expected 0", dsel(2)); end
        n_tests++; if (max_run > 1) begin n_fail++; $display("FAIL zero_den_busy: got %0d busy cycles expected 1", max_run); end
    endtask

    task automatic test_overrun;
        int e0, cnt1, val1;
        logic [NUM_CH-1:0] ov1, ov2;
        logic busy_mid;
        e0 = -1; cnt1 = 0; val1 = -1; ov1 = 'x; ov2 = 'x; busy_mid = 1'b0;
        set_pair(0, 20, 80);
        pulse(3'b001);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (duty_valid[0] && e0 < 0) e0 = k;
            if (duty_valid[1]) begin cnt1++; val1 = int'(dsel(1)); end
            if (k == 3) begin set_pair(1, 40, 60); meas_valid = 3'b010; end
            else if (k == 4) begin meas_valid = '0; ov1 = overrun; busy_mid = busy; end
            else if (k == 5) begin set_pair(1, 60, 40); meas_valid = 3'b010; end
            else if (k == 6) begin meas_valid = '0; ov2 = overrun; end
        end
        n_tests++; if (ov1 !== 3'b000 || busy_mid !== 1'b1) begin n_fail++; $display("FAIL ovr_first: got overrun=%b busy=%b expected 000/1", ov1, busy_mid); end
        n_tests++; if (ov2 !== 3'b010) begin n_fail++; $display("FAIL ovr_second: got %b expected 010", ov2); end
        n_tests++; if (e0 != 9 || dsel(0) !== 8'd20) begin n_fail++; $display("FAIL ovr_ch0: got %0d at edge %0d expected 20 at 9", dsel(0), e0); end
        n_tests++; if (cnt1 != 1 || val1 != 60) begin n_fail++; $display("FAIL ovr_ch1: got %0d pulses duty %0d expected 1 pulse duty 60", cnt1, val1); end
        n_tests++; if (overrun !== 3'b010) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 010", overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_tests++; if (overrun !== 3'b000) begin n_fail++; $display("FAIL ovr_clr: got %b expected 000", overrun); end
    endtask

    task automatic test_reset_mid_calc;
        int nvalid, nbusy;
        logic busy_pre;
        nvalid = 0; nbusy = 0;
        set_pair(0, 50, 50); set_pair(1, 30, 70);
        pulse(3'b011);
        tick(); tick(); tick(); tick();
        busy_pre = busy;
        reset = 1'b0;
        #2;
        n_tests++; if (busy_pre !== 1'b1) begin n_fail++; $display("FAIL rst_mid_precond: got busy=%b expected 1", busy_pre); end
        n_tests++; if (duty !== '0 || duty_valid !== '0 || busy !== 1'b0 || overrun !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got duty=%h valid=%b busy=%b ovr=%b expected all 0", duty, duty_valid, busy, overrun);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (duty_valid != '0) nvalid++;
            if (busy) nbusy++;
        end
        n_tests++; if (nvalid != 0 || nbusy != 0) begin n_fail++; $display("FAIL rst_mid_pending_lost: got %0d valid %0d busy cycles expected 0/0", nvalid, nbusy); end
    endtask

    task automatic test_en_gating;
        int nvalid, nbusy, e;
        nvalid = 0; nbusy = 0;
        en = 1'b0;
        set_pair(0, 10, 90); set_pair(1, 90, 10);
        pulse(3'b011);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (duty_valid != '0) nvalid++;
            if (busy) nbusy++;
        end
        n_tests++; if (nvalid != 0 || nbusy != 0) begin n_fail++; $display("FAIL en_hold: got %0d valid %0d busy cycles expected 0/0", nvalid, nbusy); end
        en = 1'b1;
        rec_n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 2) en = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (duty_valid[c] && rec_n < 8) begin
                    rec_ch[rec_n] = c; rec_edge[rec_n] = k; rec_val[rec_n] = int'(dsel(c)); rec_n++;
                end
            end
        end
        n_tests++; if (rec_n != 1 || rec_ch[0] != 0 || rec_edge[0] != 9 || rec_val[0] != 10) begin
            n_fail++; $display("FAIL en_inflight: got %0d pulses first ch%0d edge %0d duty %0d expected 1 pulse ch0 edge 9 duty 10",
                               rec_n, rec_ch[0], rec_edge[0], rec_val[0]);
        end
        en = 1'b1;
        wait_valid(1, e);
        n_tests++; if (e != 9 || dsel(1) !== 8'd90) begin n_fail++; $display("FAIL en_resume: got %0d at edge %0d expected 90 at 9", dsel(1), e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_truncation();
        test_round_robin();
        test_zero_den();
        test_overrun();
        test_reset_mid_calc();
        test_en_gating();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
